// File: rtl/opti_mult_arbiter.sv
// opti_mult_arbiter: round-robin scheduler that shares one fully pipelined
// Q2.22 multiplier among NREQ requesters. Each issued operation carries a tag
// through a LAT-deep shift register so its result is routed back to the
// requester that issued it. A sticky err flag records any cycle where the tag
// pipeline and the multiplier's valid output disagree.
// Optional per-requester grant statistics: define OPTI_MULT_ARB_STATS_EN.
module opti_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 14,
  parameter int TW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*24-1:0] req_a,
  input  logic [NREQ*24-1:0] req_b,
  input  logic [NREQ-1:0]    cfg_en,
  output logic [NREQ-1:0]    gnt,
  output logic               m_valid_in,
  output logic [23:0]        m_a,
  output logic [23:0]        m_b,
  input  logic [23:0]        m_p,
  input  logic               m_valid_out,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [23:0]        rsp_p,
  output logic [4:0]         inflight,
  output logic               err
`ifdef OPTI_MULT_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [NREQ*16-1:0] stat_cnt
`endif
);

  localparam int GW = $clog2(LAT + 1);

  logic [NREQ-1:0] eligible;
  logic [TW-1:0]   ptr;
  logic [TW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [23:0]     sel_a;
  logic [23:0]     sel_b;
  logic [TW-1:0]   m_tag;
  logic            pipe_v   [LAT];
  logic [TW-1:0]   pipe_tag [LAT];
  logic            tag_out_valid;
  logic [TW-1:0]   tag_out;
  logic [GW-1:0]   guard;
  logic            mismatch;

  assign eligible      = req & cfg_en;
  assign tag_out_valid = pipe_v[LAT-1];
  assign tag_out       = pipe_tag[LAT-1];
  assign mismatch      = (guard == '0) && (m_valid_out != tag_out_valid);

  // Round-robin pick: first eligible index at or above ptr, else wrap to the lowest one
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    if (!rst) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any && eligible[j] && (j >= int'(ptr))) begin
          gnt_any = 1'b1;
          gnt_idx = TW'(j);
          gnt[j]  = 1'b1;
          sel_a   = req_a[j*24 +: 24];
          sel_b   = req_b[j*24 +: 24];
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_any && eligible[j]) begin
          gnt_any = 1'b1;
          gnt_idx = TW'(j);
          gnt[j]  = 1'b1;
          sel_a   = req_a[j*24 +: 24];
          sel_b   = req_b[j*24 +: 24];
        end
      end
    end
  end

  // Issue stage: register the granted operands and tag, then move the pointer past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_in <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_tag      <= '0;
      ptr        <= '0;
    end else begin
      m_valid_in <= gnt_any;
      if (gnt_any) begin
        m_a   <= sel_a;
        m_b   <= sel_b;
        m_tag <= gnt_idx;
        ptr   <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
      end
    end
  end

  // Tag pipeline: follows each issue through the multiplier so its last stage lines up with m_valid_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_v[k]   <= 1'b0;
        pipe_tag[k] <= '0;
      end
    end else begin
      pipe_v[0]   <= m_valid_in;
      pipe_tag[0] <= m_tag;
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  // Result routing: strobe only the owner of the returning tag, and nothing on a mismatch
  always_comb begin
    rsp_valid = '0;
    rsp_p     = '0;
    if (!rst) begin
      rsp_p = m_p;
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid[i] = m_valid_out & tag_out_valid & (tag_out == TW'(i)) & ~mismatch;
      end
    end
  end

  // Bookkeeping: post-reset guard window, sticky mismatch flag and in-flight count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard    <= GW'(LAT);
      err      <= 1'b0;
      inflight <= '0;
    end else begin
      if (guard != '0) begin
        guard <= guard - GW'(1);
      end
      if (mismatch) begin
        err <= 1'b1;
      end
      case ({m_valid_in, tag_out_valid})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef OPTI_MULT_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  // Grant statistics: saturating per-requester counters, synchronous clear wins over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          cnt[i] <= '0;
        end else if (gnt[i] && (cnt[i] != 16'hFFFF)) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the export bus
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_cnt[i*16 +: 16] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_opti_mult_arbiter.sv
// tb_opti_mult_arbiter: randomized self-checking bench for opti_mult_arbiter.
// A behavioural multiplier model sits on the multiplier port; a reference
// arbiter predicts grants and pushes expected results into a scoreboard that
// a separate monitor drains whenever the DUT strobes rsp_valid.
module tb_opti_mult_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 14;
  localparam int TW   = 2;

  typedef struct {
    int          who;
    logic [23:0] p;
    int          gcyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] req_a;
  logic [NREQ*24-1:0] req_b;
  logic [NREQ-1:0]    cfg_en;
  logic [NREQ-1:0]    gnt;
  logic               m_valid_in;
  logic [23:0]        m_a;
  logic [23:0]        m_b;
  logic [23:0]        m_p;
  logic               m_valid_out;
  logic [NREQ-1:0]    rsp_valid;
  logic [23:0]        rsp_p;
  logic [4:0]         inflight;
  logic               err;
`ifdef OPTI_MULT_ARB_STATS_EN
  logic               stat_clr = 1'b0;
  logic [NREQ*16-1:0] stat_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int quiet_until = -1;

  exp_t            sb [$];
  logic [NREQ-1:0] pend = '0;
  logic [23:0]     opa [NREQ];
  logic [23:0]     opb [NREQ];
  logic [NREQ-1:0] cfg = '1;
  int              fill_pct = 0;
  int              cfg_churn = 0;
  int              mptr = 0;
  int              last_acc = -1;
  logic [23:0]     last_a;
  logic [23:0]     last_b;
  logic            exp_err = 1'b0;
  logic            force_v = 1'b0;

  logic            mv [LAT];
  logic [23:0]     mp [LAT];

  opti_mult_arbiter #(.NREQ(NREQ), .LAT(LAT), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .cfg_en      (cfg_en),
    .gnt         (gnt),
    .m_valid_in  (m_valid_in),
    .m_a         (m_a),
    .m_b         (m_b),
    .m_p         (m_p),
    .m_valid_out (m_valid_out),
    .rsp_valid   (rsp_valid),
    .rsp_p       (rsp_p),
    .inflight    (inflight),
    .err         (err)
`ifdef OPTI_MULT_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp grants and responses
  always @(posedge clk) cyc <= cyc + 1;

  // Q2.22 signed multiply with saturation to the 24-bit range
  function automatic logic [23:0] mulq(input logic [23:0] a, input logic [23:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> 22;
    if (p > 64'sd8388607) return 24'h7FFFFF;
    if (p < -64'sd8388608) return 24'h800000;
    return p[23:0];
  endfunction

  // Reference arbiter: first eligible requester counting up from the pointer with wraparound
  function automatic int pickModel(input logic [NREQ-1:0] elig, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [23:0] randOp();
    case ($urandom_range(3))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  // Behavioural multiplier: fixed LAT-cycle pipeline, deliberately not reset so stale results survive a reset
  always @(posedge clk) begin
    mv[0] <= m_valid_in;
    mp[0] <= mulq(m_a, m_b);
    for (int k = 1; k < LAT; k++) begin
      mv[k] <= mv[k-1];
      mp[k] <= mp[k-1];
    end
  end

  assign m_valid_out = mv[LAT-1] | force_v;
  assign m_p         = mp[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*24 +: 24] = opa[i];
      req_b[i*24 +: 24] = opb[i];
    end
    req    = pend;
    cfg_en = cfg;
  endtask

  // One cycle per iteration: predict and check the grant, log the expected result, then refresh requesters
  task automatic applyStimulus(input int ncycles);
    int   acc;
    exp_t e;
    repeat (ncycles) begin
      @(negedge clk);
      checkOutput("m_valid_in", {31'd0, m_valid_in}, {31'd0, last_acc >= 0});
      if (last_acc >= 0) begin
        checkOutput("m_a", {8'd0, m_a}, {8'd0, last_a});
        checkOutput("m_b", {8'd0, m_b}, {8'd0, last_b});
      end
      acc = pickModel(pend & cfg, mptr);
      checkOutput("gnt", {28'd0, gnt}, (acc >= 0) ? (32'd1 << acc) : 32'd0);
      if (acc >= 0) begin
        e.who  = acc;
        e.p    = mulq(opa[acc], opb[acc]);
        e.gcyc = cyc;
        sb.push_back(e);
        last_a = opa[acc];
        last_b = opb[acc];
        mptr   = (acc + 1) % NREQ;
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      if (acc >= 0) pend[acc] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(99) < fill_pct)) begin
          pend[i] = 1'b1;
          opa[i]  = randOp();
          opb[i]  = randOp();
        end
      end
      if ($urandom_range(99) < cfg_churn) cfg = NREQ'($urandom);
      driveInputs();
    end
  endtask

  task automatic doReset(input int hold_cycles);
    rst      = 1'b1;
    sb.delete();
    mptr     = 0;
    exp_err  = 1'b0;
    last_acc = -1;
    repeat (hold_cycles) begin
      @(negedge clk);
      checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
      checkOutput("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_p", {8'd0, rsp_p}, 32'd0);
      checkOutput("rst_m_valid_in", {31'd0, m_valid_in}, 32'd0);
      checkOutput("rst_m_a", {8'd0, m_a}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet_until = cyc + LAT;
  endtask

  int   mon_n;
  exp_t mon_e;

  // Monitor: checks in-flight count and err every cycle, pops the scoreboard on each response
  always @(negedge clk) begin
    mon_n = 0;
    foreach (sb[k]) if (cyc >= sb[k].gcyc + 2) mon_n++;
    checkOutput("inflight", {27'd0, inflight}, mon_n);
    checkOutput("err", {31'd0, err}, {31'd0, exp_err});
    if (cyc <= quiet_until) checkOutput("quiet_rsp", {28'd0, rsp_valid}, 32'd0);
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_valid", {28'd0, rsp_valid}, 32'd1 << mon_e.who);
        checkOutput("rsp_p", {8'd0, rsp_p}, {8'd0, mon_e.p});
        checkOutput("rsp_cycle", cyc, mon_e.gcyc + 1 + LAT);
      end
    end else if (sb.size() > 0 && cyc > sb[0].gcyc + 1 + LAT) begin
      mon_e = sb.pop_front();
      checkOutput("rsp_timeout", 32'd0, 32'd1 << mon_e.who);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: no summary by time limit, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    driveInputs();
    #1;
    pend = '1;
    driveInputs();
    doReset(20);
    pend = '0;
    driveInputs();

    $display("[TB] single requester 1.0 * 0.5");
    opa[0] = 24'h400000;
    opb[0] = 24'h200000;
    pend[0] = 1'b1;
    driveInputs();
    applyStimulus(LAT + 6);

    $display("[TB] all requesters continuous from ptr 0");
    doReset(2);
    pend = '1;
    cfg  = 4'hF;
    fill_pct = 100;
    driveInputs();
    applyStimulus(40);
    fill_pct = 0;
    pend = '0;
    driveInputs();
    applyStimulus(LAT + 4);

    $display("[TB] masking cfg_en=1101");
    doReset(2);
    cfg  = 4'b1101;
    pend = '1;
    fill_pct = 100;
    driveInputs();
    applyStimulus(30);
    fill_pct = 0;
    pend = '0;
    cfg  = 4'hF;
    driveInputs();
    applyStimulus(LAT + 4);

    $display("[TB] saturation passthrough on requester 2");
    opa[2] = 24'h3FFFFF; opb[2] = 24'h3FFFFF; pend[2] = 1'b1;
    driveInputs();
    applyStimulus(2);
    opa[2] = 24'h7FFFFF; opb[2] = 24'h7FFFFF; pend[2] = 1'b1;
    driveInputs();
    applyStimulus(2);
    opa[2] = 24'h800000; opb[2] = 24'h800000; pend[2] = 1'b1;
    driveInputs();
    applyStimulus(LAT + 4);

    $display("[TB] randomized traffic with cfg_en churn");
    fill_pct  = 60;
    cfg_churn = 10;
    applyStimulus(300);
    fill_pct  = 0;
    cfg_churn = 0;
    pend = '0;
    cfg  = 4'hF;
    driveInputs();
    applyStimulus(LAT + 4);

    $display("[TB] fault injection on m_valid_out");
    last_acc = -1;
    @(posedge clk);
    #1;
    force_v = 1'b1;
    @(negedge clk);
    checkOutput("fault_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    force_v = 1'b0;
    exp_err = 1'b1;
    applyStimulus(6);
    doReset(2);
    applyStimulus(3);

    $display("[TB] reset with operations in flight");
    pend = '1;
    fill_pct = 100;
    driveInputs();
    applyStimulus(10);
    doReset(3);
    fill_pct = 50;
    applyStimulus(LAT + 10);
    fill_pct = 0;
    pend = '0;
    driveInputs();
    applyStimulus(LAT + 4);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
